// File: rtl/alu_issue_stage_if.sv
// Handshake/datapath bundle around the ALU issue stage: upstream micro-op,
// ALU launch port and registered writeback result.
// The stage connects through the slave modport; its neighbours use master.
interface alu_issue_stage_if #(
    parameter int XLEN = 16,
    parameter int RD_W = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_fn;
    logic [1:0]      in_op1_sel;
    logic [1:0]      in_op2_sel;
    logic [RD_W-1:0] in_rs1;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [RD_W-1:0] in_rd;
    logic            in_wb_en;

    logic [3:0]      alu_fn;
    logic [XLEN-1:0] alu_src1;
    logic [XLEN-1:0] alu_src2;
    logic [XLEN-1:0] alu_out;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wb_en;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_fn, in_op1_sel, in_op2_sel, in_rs1, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_rd, in_wb_en,
        output in_ready,
        output alu_fn, alu_src1, alu_src2,
        input  alu_out,
        output out_valid, out_result, out_rd, out_wb_en, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_fn, in_op1_sel, in_op2_sel, in_rs1, in_rs1_data,
               in_rs2_data, in_imm, in_pc, in_rd, in_wb_en,
        input  in_ready,
        input  alu_fn, alu_src1, alu_src2,
        output alu_out,
        input  out_valid, out_result, out_rd, out_wb_en, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue/writeback stage: muxes operands for the external combinational
// ALU and holds its result in a single valid/ready output register.
// Optional feature macro: ALU_ISSUE_FWD_EN enables a 1-deep rs1 bypass from
// the held result into alu_src1.
// ALU function codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL,
// 7 SRA, 8 OR, 9 AND, 10 PASS2; 15 is ALU_X; 11..14 are undefined.
module alu_issue_stage #(
    parameter int XLEN  = 16,
    parameter int RD_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_issue_stage_if.slave    bus,
    output logic [CNT_W-1:0]    issued_cnt
);
    localparam logic [3:0] ALU_LAST_DEFINED = 4'd10;

    localparam logic [1:0] OP1_RS1 = 2'd0;
    localparam logic [1:0] OP1_PC  = 2'd1;
    localparam logic [1:0] OP2_RS2 = 2'd0;
    localparam logic [1:0] OP2_IMM = 2'd1;
    localparam logic [1:0] OP2_TWO = 2'd2;

    logic            accept;
    logic            fn_legal;
    logic [XLEN-1:0] op1_mux;
    logic [XLEN-1:0] op2_mux;

    // Operand 1 select; reserved encoding reads as zero.
    always_comb begin
        op1_mux = '0;
        case (bus.in_op1_sel)
            OP1_RS1: op1_mux = bus.in_rs1_data;
            OP1_PC:  op1_mux = bus.in_pc;
            default: op1_mux = '0;
        endcase
    end

    // Operand 2 select; reserved encoding reads as zero.
    always_comb begin
        op2_mux = '0;
        case (bus.in_op2_sel)
            OP2_RS2: op2_mux = bus.in_rs2_data;
            OP2_IMM: op2_mux = bus.in_imm;
            OP2_TWO: op2_mux = XLEN'(2);
            default: op2_mux = '0;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_hit;

    // Bypass the held result into rs1 when it targets the same register;
    // x0 never forwards and the held result counts even while stalled.
    always_comb begin
        fwd_hit = (bus.in_op1_sel == OP1_RS1) && bus.out_valid && bus.out_wb_en
                  && (bus.out_rd == bus.in_rs1) && (bus.in_rs1 != '0);
    end

    assign bus.alu_src1 = fwd_hit ? bus.out_result : op1_mux;
`else
    // rs1 index only feeds the bypass; upstream stalls on hazards instead.
    logic unused_rs1;
    assign unused_rs1   = ^bus.in_rs1;
    assign bus.alu_src1 = op1_mux;
`endif

    assign bus.alu_fn   = bus.in_fn;
    assign bus.alu_src2 = op2_mux;

    // ALU_X (15) and 11..14 all fall above the last defined code.
    assign fn_legal     = (bus.in_fn <= ALU_LAST_DEFINED);
    assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Result register: flush drops it, accept reloads it, a taken result
    // with nothing behind it empties the stage, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_result  <= '0;
            bus.out_rd      <= '0;
            bus.out_wb_en   <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (flush) begin
            bus.out_valid   <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_result  <= bus.alu_out;
            bus.out_rd      <= bus.in_rd;
            bus.out_wb_en   <= bus.in_wb_en && fn_legal;
            bus.out_illegal <= !fn_legal;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

    // Accepted micro-op counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
        end else if (accept) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU model.
module tb_alu_issue_stage;
    localparam int XLEN  = 16;
    localparam int RD_W  = 3;
    localparam int CNT_W = 16;

    localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SLL = 4'd2, F_SLT = 4'd3,
                           F_SLTU = 4'd4, F_XOR = 4'd5, F_SRL = 4'd6, F_SRA = 4'd7,
                           F_OR = 4'd8, F_AND = 4'd9, F_PASS2 = 4'd10, F_X = 4'd15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_stage_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [3:0] fn, input logic [15:0] a,
                                            input logic [15:0] b);
        case (fn)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_SLL:   return a << b[3:0];
            F_SLT:   return {15'd0, $signed(a) < $signed(b)};
            F_SLTU:  return {15'd0, a < b};
            F_XOR:   return a ^ b;
            F_SRL:   return a >> b[3:0];
            F_SRA:   return 16'($signed(a) >>> b[3:0]);
            F_OR:    return a | b;
            F_AND:   return a & b;
            F_PASS2: return b;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_fn, bus.alu_src1, bus.alu_src2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  fn;
        logic [1:0]  op1_sel;
        logic [1:0]  op2_sel;
        logic [15:0] rs1_data;
        logic [15:0] rs2_data;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [2:0]  rd;
        logic        wb_en;
        logic [15:0] exp_result;
        logic        exp_wb_en;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[14];

    task automatic drive_op(input logic [3:0] fn, input logic [1:0] s1, input logic [1:0] s2,
                            input logic [2:0] rs1, input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] imm, input logic [15:0] pc,
                            input logic [2:0] rd, input logic wb);
        bus.in_fn       = fn;
        bus.in_op1_sel  = s1;
        bus.in_op2_sel  = s2;
        bus.in_rs1      = rs1;
        bus.in_rs1_data = d1;
        bus.in_rs2_data = d2;
        bus.in_imm      = imm;
        bus.in_pc       = pc;
        bus.in_rd       = rd;
        bus.in_wb_en    = wb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] cnt_base;
    logic [15:0] exp_src1;
    logic [15:0] exp_fwd_res;

    initial begin
        //            fn       s1    s2    rs1     rs2     imm     pc      rd    wb    res     wbo   ill
        vecs[0]  = '{F_ADD,   2'd0, 2'd1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 3'd1, 1'b1, 16'h8000, 1'b1, 1'b0};
        vecs[1]  = '{F_SUB,   2'd0, 2'd0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 3'd2, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[2]  = '{F_ADD,   2'd1, 2'd2, 16'h1234, 16'h5555, 16'h0007, 16'h1000, 3'd3, 1'b1, 16'h1002, 1'b1, 1'b0};
        vecs[3]  = '{F_XOR,   2'd2, 2'd0, 16'hAAAA, 16'h00FF, 16'h0000, 16'h0000, 3'd4, 1'b1, 16'h00FF, 1'b1, 1'b0};
        vecs[4]  = '{F_AND,   2'd3, 2'd1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 3'd5, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{F_OR,    2'd0, 2'd3, 16'hF000, 16'h0F0F, 16'h00F0, 16'h0000, 3'd6, 1'b1, 16'hF000, 1'b1, 1'b0};
        vecs[6]  = '{F_X,     2'd0, 2'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 3'd7, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{4'd11,   2'd0, 2'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 3'd1, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{F_ADD,   2'd0, 2'd1, 16'h0005, 16'h0000, 16'h0003, 16'h0000, 3'd0, 1'b1, 16'h0008, 1'b1, 1'b0};
        vecs[9]  = '{F_SLL,   2'd0, 2'd1, 16'h0001, 16'h0000, 16'h0004, 16'h0000, 3'd2, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[10] = '{F_SRA,   2'd0, 2'd1, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 3'd3, 1'b1, 16'hC000, 1'b1, 1'b0};
        vecs[11] = '{F_SLT,   2'd0, 2'd1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 3'd4, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[12] = '{F_SLTU,  2'd0, 2'd1, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 3'd5, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[13] = '{F_PASS2, 2'd0, 2'd2, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1'b1, 16'h0002, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_op(F_ADD, 2'd0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_wb_en", 32'(bus.out_wb_en), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back table vectors with writeback always ready.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_op(vecs[i].fn, vecs[i].op1_sel, vecs[i].op2_sel, 3'd0, vecs[i].rs1_data,
                     vecs[i].rs2_data, vecs[i].imm, vecs[i].pc, vecs[i].rd, vecs[i].wb_en);
            #1;
            chk($sformatf("vec%0d_alu_fn", i), 32'(bus.alu_fn), 32'(vecs[i].fn));
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'(bus.out_result), 32'(vecs[i].exp_result));
            chk($sformatf("vec%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_wb_en", i), 32'(bus.out_wb_en), 32'(vecs[i].exp_wb_en));
            chk($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(vecs[i].exp_illegal));
            chk($sformatf("vec%0d_cnt", i), 32'(issued_cnt), 32'(i + 1));
        end

        // Drain: nothing offered, result taken.
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_cnt", 32'(issued_cnt), 32'd14);

        // Backpressure: two ops offered while writeback stalls.
        cnt_base = issued_cnt;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_op(F_ADD, 2'd0, 2'd1, 3'd0, 16'h0001, 16'h0, 16'h0001, 16'h0, 3'd2, 1'b1);
        step();
        chk("bp_first_result", 32'(bus.out_result), 32'h0002);
        drive_op(F_ADD, 2'd0, 2'd1, 3'd0, 16'h0003, 16'h0, 16'h0003, 16'h0, 3'd5, 1'b1);
        step();
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_result", 32'(bus.out_result), 32'h0002);
        chk("bp_hold_rd", 32'(bus.out_rd), 32'd2);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_cnt1", 32'(issued_cnt), 32'(cnt_base + 16'd1));
        step();
        chk("bp_hold_result2", 32'(bus.out_result), 32'h0002);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_second_result", 32'(bus.out_result), 32'h0006);
        chk("bp_second_rd", 32'(bus.out_rd), 32'd5);
        chk("bp_cnt2", 32'(issued_cnt), 32'(cnt_base + 16'd2));

        // Flush beats both handshakes.
        flush = 1'b1;
        drive_op(F_ADD, 2'd0, 2'd1, 3'd0, 16'h0100, 16'h0, 16'h0001, 16'h0, 3'd7, 1'b1);
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_cnt", 32'(issued_cnt), 32'(cnt_base + 16'd2));
        chk("flush_rd_kept", 32'(bus.out_rd), 32'd5);

        // Bypass: A (rd=3, 0x0010) held; B reads rs1=3.
        cnt_base = issued_cnt;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_op(F_ADD, 2'd0, 2'd1, 3'd0, 16'h000F, 16'h0, 16'h0001, 16'h0, 3'd3, 1'b1);
        step();
        chk("fwd_a_result", 32'(bus.out_result), 32'h0010);
        drive_op(F_ADD, 2'd0, 2'd1, 3'd3, 16'h0000, 16'h0, 16'h0001, 16'h0, 3'd4, 1'b1);
`ifdef ALU_ISSUE_FWD_EN
        exp_src1    = 16'h0010;
        exp_fwd_res = 16'h0011;
`else
        exp_src1    = 16'h0000;
        exp_fwd_res = 16'h0001;
`endif
        #1;
        chk("fwd_src1_stalled", 32'(bus.alu_src1), 32'(exp_src1));
        step();
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("fwd_b_result", 32'(bus.out_result), 32'(exp_fwd_res));
        chk("fwd_cnt", 32'(issued_cnt), 32'(cnt_base + 16'd2));
        // Held B has rd=4; rs1=0 must never bypass.
        drive_op(F_ADD, 2'd0, 2'd0, 3'd0, 16'h0077, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0);
        #1;
        chk("fwd_x0_src1", 32'(bus.alu_src1), 32'h0077);

        // Async reset mid-operation drops the held result without a clock edge.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_cnt", 32'(issued_cnt), 32'd0);
        chk("midrst_result", 32'(bus.out_result), 32'd0);
        step();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
